hazard_scoreboard: RTL and testbench

//  Sequences issue from the decode stage into execute by tracking in-flight destination registers.

---
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Brief    : Decode/writeback/kill bundle and status outputs of the scoreboard.
// Revision : 1.0
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
);
    logic [XLEN-1:0]     instr_decode;
    logic                decode_valid;
    logic                reg_write_en;
    logic [4:0]          wb_rd;
    logic                kill_valid;
    logic [4:0]          kill_rd;
    logic                stall_decode;
    logic                issue_fire;
    logic [NUM_REGS-1:0] pending_vec;
    logic [31:0]         perf_stall_cnt;
    logic                sb_err;

    modport master (
        output instr_decode, decode_valid, reg_write_en, wb_rd, kill_valid, kill_rd,
        input  stall_decode, issue_fire, pending_vec, perf_stall_cnt, sb_err
    );

    modport slave (
        input  instr_decode, decode_valid, reg_write_en, wb_rd, kill_valid, kill_rd,
        output stall_decode, issue_fire, pending_vec, perf_stall_cnt, sb_err
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Per-register in-flight write counters gating decode->execute issue.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  sb
);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_REGS-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_REGS-1:0]            r_pending;
    logic [31:0]                    r_perf;
    logic                           r_err;

    wire  [NUM_REGS-1:0][CNT_W-1:0] w_cnt_nxt;
    wire  [NUM_REGS-1:0]            w_err_vec;

    logic [6:0] w_opcode;
    logic [4:0] w_rs1, w_rs2, w_rd;
    logic       w_use_rs1, w_use_rs2, w_wr_rd;
    logic       w_raw, w_waw, w_stall, w_issue;

    wire w_unused = &{1'b0, sb.instr_decode[XLEN-1:25], sb.instr_decode[14:12]};

    assign w_opcode = sb.instr_decode[6:0];
    assign w_rd     = sb.instr_decode[11:7];
    assign w_rs1    = sb.instr_decode[19:15];
    assign w_rs2    = sb.instr_decode[24:20];

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_wr_rd   = 1'b0;
        case (w_opcode)
            c_OP_LUI, c_OP_AUIPC, c_OP_JAL: w_wr_rd = 1'b1;
            c_OP_JALR, c_OP_LOAD, c_OP_OPIMM: begin
                w_use_rs1 = 1'b1;
                w_wr_rd   = 1'b1;
            end
            c_OP_BRANCH, c_OP_STORE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            c_OP_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_wr_rd   = 1'b1;
            end
            default: ;
        endcase
    end

    // Only registered counters are consulted: a writeback frees its source one cycle later.
    assign w_raw   = (w_use_rs1 && (w_rs1 != 5'd0) && (r_cnt[w_rs1] != '0)) ||
                     (w_use_rs2 && (w_rs2 != 5'd0) && (r_cnt[w_rs2] != '0));
    assign w_waw   = w_wr_rd && (w_rd != 5'd0) && (r_cnt[w_rd] == c_CNT_MAX);
    assign w_stall = sb.decode_valid && (w_raw || w_waw);
    assign w_issue = sb.decode_valid && !w_stall;

    assign w_cnt_nxt[0] = '0;
    assign w_err_vec[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        localparam logic [4:0] c_IDX = 5'(r);
        logic           w_inc, w_dwb, w_dkill, w_under;
        logic [1:0]     w_ndec;
        logic [CNT_W:0] w_avail, w_ndec_ext, w_apply;

        assign w_inc      = w_issue && w_wr_rd && (w_rd == c_IDX);
        assign w_dwb      = sb.reg_write_en && (sb.wb_rd == c_IDX);
        assign w_dkill    = sb.kill_valid && (sb.kill_rd == c_IDX);
        assign w_avail    = {1'b0, r_cnt[r]} + {{CNT_W{1'b0}}, w_inc};
        assign w_ndec     = {1'b0, w_dwb} + {1'b0, w_dkill};
        assign w_ndec_ext = (CNT_W+1)'(w_ndec);
        // Decrements beyond what is in flight are dropped and flagged.
        assign w_under    = (w_ndec_ext > w_avail);
        assign w_apply    = w_under ? w_avail : w_ndec_ext;

        assign w_cnt_nxt[r] = CNT_W'(w_avail - w_apply);
        assign w_err_vec[r] = w_under;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_pending <= '0;
            r_perf    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_pending[i] <= (w_cnt_nxt[i] != '0);
            end
            if (w_stall && (r_perf != 32'hFFFF_FFFF)) begin
                r_perf <= r_perf + 32'd1;
            end
            r_err <= r_err | (|w_err_vec);
        end
    end

    assign sb.stall_decode   = w_stall;
    assign sb.issue_fire     = w_issue;
    assign sb.pending_vec    = r_pending;
    assign sb.perf_stall_cnt = r_perf;
    assign sb.sb_err         = r_err;
endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed self-checking bench for hazard_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_hazard_scoreboard;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    hazard_scoreboard_if #(.XLEN(32), .NUM_REGS(32)) sb_if ();

    hazard_scoreboard #(.XLEN(32), .NUM_REGS(32), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd1, rs1, f3, rd, opc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sb_if.decode_valid = 1'b0;
        sb_if.instr_decode = 32'h0;
        sb_if.reg_write_en = 1'b0;
        sb_if.wb_rd        = 5'd0;
        sb_if.kill_valid   = 1'b0;
        sb_if.kill_rd      = 5'd0;
    endtask

    task automatic decode(input logic [31:0] ins);
        sb_if.instr_decode = ins;
        sb_if.decode_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("reset_pending", sb_if.pending_vec, 32'h0);
        chk("reset_perf", sb_if.perf_stall_cnt, 32'h0);
        chk("reset_err", {31'b0, sb_if.sb_err}, 32'h0);
        rst_n = 1'b1;
        tick();

        // ADD x5,x1,x2 issues immediately
        decode(enc_r(7'h00, 5'd5, 5'd1, 5'd2));
        #1;
        chk("t1_stall", {31'b0, sb_if.stall_decode}, 32'h0);
        chk("t1_fire", {31'b0, sb_if.issue_fire}, 32'h1);
        tick();
        chk("t1_pending", sb_if.pending_vec, 32'h0000_0020);

        // Unknown opcode with x5 in operand fields never stalls nor tracks
        decode({7'h00, 5'd5, 5'd5, 3'b000, 5'd5, 7'b1110011});
        #1;
        chk("other_stall", {31'b0, sb_if.stall_decode}, 32'h0);
        chk("other_fire", {31'b0, sb_if.issue_fire}, 32'h1);
        tick();
        chk("other_pending", sb_if.pending_vec, 32'h0000_0020);

        // SUB x6,x5,x3 stalls on RAW until the cycle after wb of x5
        decode(enc_r(7'h20, 5'd6, 5'd5, 5'd3));
        #1;
        chk("t2_stall", {31'b0, sb_if.stall_decode}, 32'h1);
        chk("t2_fire", {31'b0, sb_if.issue_fire}, 32'h0);
        tick();
        tick();
        chk("t2_perf2", sb_if.perf_stall_cnt, 32'd2);
        sb_if.reg_write_en = 1'b1;
        sb_if.wb_rd        = 5'd5;
        #1;
        chk("t2_no_bypass", {31'b0, sb_if.stall_decode}, 32'h1);
        tick();
        sb_if.reg_write_en = 1'b0;
        #1;
        chk("t2_released", {31'b0, sb_if.issue_fire}, 32'h1);
        chk("t2_pending_clr", sb_if.pending_vec, 32'h0);
        tick();
        chk("t2_pending6", sb_if.pending_vec, 32'h0000_0040);
        chk("t2_perf3", sb_if.perf_stall_cnt, 32'd3);
        idle_inputs();
        sb_if.reg_write_en = 1'b1;
        sb_if.wb_rd        = 5'd6;
        tick();
        idle_inputs();
        chk("t2_drain", sb_if.pending_vec, 32'h0);

        // Three LW x7 fill the counter; the fourth stalls on WAW saturation
        decode(enc_i(7'b0000011, 3'b010, 5'd7, 5'd0));
        #1;
        chk("t3_fire1", {31'b0, sb_if.issue_fire}, 32'h1);
        tick();
        tick();
        chk("t3_fire3", {31'b0, sb_if.issue_fire}, 32'h1);
        tick();
        chk("t3_pending", sb_if.pending_vec, 32'h0000_0080);
        chk("t3_sat_stall", {31'b0, sb_if.stall_decode}, 32'h1);
        tick();
        chk("t3_perf4", sb_if.perf_stall_cnt, 32'd4);
        sb_if.reg_write_en = 1'b1;
        sb_if.wb_rd        = 5'd7;
        tick();
        sb_if.reg_write_en = 1'b0;
        #1;
        chk("t3_release", {31'b0, sb_if.issue_fire}, 32'h1);
        chk("t3_perf5", sb_if.perf_stall_cnt, 32'd5);
        tick();
        idle_inputs();
        sb_if.reg_write_en = 1'b1;
        sb_if.wb_rd        = 5'd7;
        tick();
        tick();
        chk("t3_still_pend", sb_if.pending_vec, 32'h0000_0080);
        tick();
        idle_inputs();
        chk("t3_drain", sb_if.pending_vec, 32'h0);
        chk("t3_err", {31'b0, sb_if.sb_err}, 32'h0);

        // ADDI x9 then kill x9
        decode(enc_i(7'b0010011, 3'b000, 5'd9, 5'd0));
        tick();
        chk("t4_pending", sb_if.pending_vec, 32'h0000_0200);
        idle_inputs();
        sb_if.kill_valid = 1'b1;
        sb_if.kill_rd    = 5'd9;
        tick();
        idle_inputs();
        chk("t4_killed", sb_if.pending_vec, 32'h0);
        chk("t4_err", {31'b0, sb_if.sb_err}, 32'h0);

        // Same-cycle issue and writeback on x4 nets to no change
        decode(enc_r(7'h00, 5'd4, 5'd0, 5'd0));
        tick();
        sb_if.reg_write_en = 1'b1;
        sb_if.wb_rd        = 5'd4;
        #1;
        chk("t5_fire", {31'b0, sb_if.issue_fire}, 32'h1);
        tick();
        chk("t5_pending", sb_if.pending_vec, 32'h0000_0010);
        sb_if.decode_valid = 1'b0;
        tick();
        idle_inputs();
        chk("t5_cnt_one", sb_if.pending_vec, 32'h0);
        chk("t5_err", {31'b0, sb_if.sb_err}, 32'h0);

        // Writeback to an idle register flags an error; x0 is never tracked
        sb_if.reg_write_en = 1'b1;
        sb_if.wb_rd        = 5'd3;
        tick();
        idle_inputs();
        chk("t6_err", {31'b0, sb_if.sb_err}, 32'h1);
        chk("t6_pending", sb_if.pending_vec, 32'h0);
        decode(enc_r(7'h00, 5'd0, 5'd0, 5'd0));
        #1;
        chk("t6_x0_stall", {31'b0, sb_if.stall_decode}, 32'h0);
        chk("t6_x0_fire", {31'b0, sb_if.issue_fire}, 32'h1);
        tick();
        idle_inputs();
        chk("t6_x0_pending", sb_if.pending_vec, 32'h0);
        chk("t6_err_sticky", {31'b0, sb_if.sb_err}, 32'h1);

        // Asynchronous reset mid-operation clears everything
        decode(enc_r(7'h00, 5'd5, 5'd0, 5'd0));
        tick();
        idle_inputs();
        chk("rst_pre_pending", sb_if.pending_vec, 32'h0000_0020);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pending", sb_if.pending_vec, 32'h0);
        chk("arst_err", {31'b0, sb_if.sb_err}, 32'h0);
        chk("arst_perf", sb_if.perf_stall_cnt, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Writeback and kill of x9 together with one in flight: one applies, one errors
        decode(enc_i(7'b0010011, 3'b000, 5'd9, 5'd0));
        tick();
        idle_inputs();
        sb_if.reg_write_en = 1'b1;
        sb_if.wb_rd        = 5'd9;
        sb_if.kill_valid   = 1'b1;
        sb_if.kill_rd      = 5'd9;
        tick();
        idle_inputs();
        chk("dbl_pending", sb_if.pending_vec, 32'h0);
        chk("dbl_err", {31'b0, sb_if.sb_err}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
